// File: rtl/aes_out_ser_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_out_ser_if
// Description : Byte-wide valid/ready stream carrying ciphertext to the host.
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_out_ser_if;
    logic [7:0] text_out;
    logic       out_valid;
    logic       out_last;
    logic       out_ready;

    modport master (
        output text_out,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  text_out,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/aes_out_ser.sv
`default_nettype none
// ============================================================================
// Module      : aes_out_ser
// Description : Final AddRoundKey capture and byte-serial ciphertext output.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_out_ser #(
    parameter int NBYTES    = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  done_i,
    input  logic [8*NBYTES-1:0]   sa_i,
    input  logic [8*NBYTES-1:0]   w_i,
    aes_out_ser_if.master         bus,
    output logic                  busy_o,
    output logic                  overrun_o
);

    localparam int c_cnt_w = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NBYTES - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                r_state;
    logic [8*NBYTES-1:0]   r_buf;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [7:0]            r_text;
    logic                  r_last;
    logic                  r_overrun;

    state_t                w_state_nxt;
    logic [8*NBYTES-1:0]   w_buf_nxt;
    logic [c_cnt_w-1:0]    w_cnt_nxt;
    logic [c_cnt_w-1:0]    w_idx;
    logic [7:0]            w_text_nxt;
    logic                  w_last_nxt;
    logic                  w_overrun_nxt;
    logic                  w_valid;
    logic                  w_xfer;
    logic                  w_final_xfer;

    assign w_valid      = (r_state == SEND);
    assign w_xfer       = w_valid & bus.out_ready;
    assign w_final_xfer = w_xfer & (r_cnt == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_buf     <= '0;
            r_cnt     <= '0;
            r_text    <= '0;
            r_last    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_buf     <= w_buf_nxt;
            r_cnt     <= w_cnt_nxt;
            r_text    <= w_text_nxt;
            r_last    <= w_last_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_buf_nxt     = r_buf;
        w_cnt_nxt     = r_cnt;
        w_overrun_nxt = r_overrun;
        w_idx         = '0;
        w_text_nxt    = 8'h00;
        w_last_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (done_i) begin
                    w_buf_nxt   = sa_i ^ w_i;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_final_xfer) begin
                    // A strobe landing on the final transfer chains the next block with no bubble
                    if (done_i) begin
                        w_buf_nxt = sa_i ^ w_i;
                        w_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    if (w_xfer) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                    if (done_i) begin
                        w_overrun_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Output byte is registered from the post-edge buffer and count
        if (w_state_nxt == SEND) begin
            w_idx      = MSB_FIRST ? (c_last - w_cnt_nxt) : w_cnt_nxt;
            w_text_nxt = w_buf_nxt[{w_idx, 3'b000} +: 8];
            w_last_nxt = (w_cnt_nxt == c_last);
        end
    end

    assign bus.text_out  = r_text;
    assign bus.out_valid = w_valid;
    assign bus.out_last  = r_last & w_valid;
    assign busy_o        = w_valid;
    assign overrun_o     = r_overrun;

endmodule
`default_nettype wire

// File: doc/aes_out_ser.md
Name: aes_out_ser

Overview:
- Output end of the byte-sliced AES datapath; counterpart to the input key-add stage that loads text_in ^ w_i into the state.
- On the final-round strobe, captures the 128-bit state XOR the final round key (last AddRoundKey) into an internal buffer.
- Streams the resulting ciphertext out one byte per transfer over a valid/ready handshake to the host-side consumer.

Parameters:
- NBYTES, 16, bytes per block; buffer is NBYTES*8 bits.
- MSB_FIRST, 1, 1 = byte NBYTES-1 (bits [8*NBYTES-1 -: 8]) sent first; 0 = byte 0 sent first.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- done_i  in  1  one-cycle final-round strobe from the round controller.
- sa_i  in  8*NBYTES  final-round state, valid while done_i=1.
- w_i  in  8*NBYTES  final round key, valid while done_i=1.
- out_ready  in  1  consumer can accept a byte this cycle.
- text_out  out  8  current output byte (registered).
- out_valid  out  1  text_out holds a valid byte.
- out_last  out  1  current byte is the last of the block.
- busy_o  out  1  block is streaming (equals out_valid).
- overrun_o  out  1  sticky: a done_i arrived while a block was still streaming.

Behaviour:
- Reset (async, rst=1): state=IDLE; buf=0; cnt=0; text_out=0; out_valid=0; out_last=0; busy_o=0; overrun_o=0.
- Capture: buf <= sa_i ^ w_i, bitwise across the full width. Evaluated only on the accepting edge.
- State IDLE:
  - done_i=1: capture, cnt <= 0, go to SEND.
  - out_valid rises on that edge, so the first byte is visible the cycle after done_i (latency 1).
- State SEND:
  - out_valid=1; text_out = buf byte selected by cnt, per MSB_FIRST.
  - A transfer occurs on an edge where out_valid & out_ready.
  - Transfer with cnt < NBYTES-1: cnt++, next byte is presented.
  - Transfer with cnt = NBYTES-1: block complete; go to IDLE unless the back-to-back rule applies.
- Handshake rules:
  - text_out and out_last stay stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer, except under reset.
- out_last = out_valid & (cnt == NBYTES-1).
- Back-to-back: done_i on the same edge as the final transfer is accepted. The block recaptures, sets cnt=0, stays in SEND, and there is no idle bubble.
- done_i in SEND at any other time: ignored (buf unchanged); overrun_o <= 1.
  - overrun_o clears only on reset.
  - done_i coincident with the last transfer does not set overrun_o.
- cnt is $clog2(NBYTES) bits wide; it never exceeds NBYTES-1 and never wraps inside a block.
- out_ready is ignored in IDLE.
- Reset mid-stream: the block is abandoned immediately; out_valid drops asynchronously and no partial state survives.

Test Plan:
- Reset release, done_i with sa_i=128'h00112233_44556677_8899aabb_ccddeeff, w_i=128'h000102..0f, MSB_FIRST=1, out_ready=1 -> out_valid the cycle after done_i. Bytes 00,10,20,30,...,e0,f0 appear on 16 consecutive cycles; out_last only on f0; then IDLE with out_valid=0.
- Same block with out_ready toggled 1,0,0,1,... -> no byte skipped or duplicated; text_out held stable during stalls; exactly 16 transfers.
- done_i asserted coincident with the 16th transfer, second block sa_i=all ones, w_i=0 -> byte ff presented on the next cycle with no gap; overrun_o stays 0.
- done_i pulsed at transfer 5 of 16 -> remaining bytes are from the first block; overrun_o=1 and stays high until rst.
- rst asserted asynchronously mid-stream at byte 7 -> out_valid, out_last and busy_o go 0 without a clock edge. A new done_i after release streams the new block from byte 0.
- MSB_FIRST=0, NBYTES=4, sa_i=32'hA1B2C3D4, w_i=0 -> output order D4,C3,B2,A1; out_last on A1.
